// File: rtl/iterative_restoring_divider_if.sv
// Request/response bundle for iterative_restoring_divider.
// signed_i exists only when DIVIDER_SIGNED_EN is defined.
interface iterative_restoring_divider_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] dividend_i;
  logic [DATA_WIDTH-1:0] divisor_i;
  logic                  data_valid_i;
  logic                  ready_o;
  logic [DATA_WIDTH-1:0] quotient_o;
  logic [DATA_WIDTH-1:0] remainder_o;
  logic                  divide_by_zero_o;
  logic                  data_valid_o;
`ifdef DIVIDER_SIGNED_EN
  logic                  signed_i;

  modport master (
    output dividend_i, divisor_i, data_valid_i, signed_i,
    input  ready_o, quotient_o, remainder_o, divide_by_zero_o, data_valid_o
  );
  modport slave (
    input  dividend_i, divisor_i, data_valid_i, signed_i,
    output ready_o, quotient_o, remainder_o, divide_by_zero_o, data_valid_o
  );
`else
  modport master (
    output dividend_i, divisor_i, data_valid_i,
    input  ready_o, quotient_o, remainder_o, divide_by_zero_o, data_valid_o
  );
  modport slave (
    input  dividend_i, divisor_i, data_valid_i,
    output ready_o, quotient_o, remainder_o, divide_by_zero_o, data_valid_o
  );
`endif
endinterface

// File: rtl/iterative_restoring_divider.sv
// Iterative restoring divider, BITS_PER_CYCLE quotient bits per clock, one op in flight.
// Optional signed operation is enabled by defining DIVIDER_SIGNED_EN.

// One restoring step: shift in a dividend bit, trial-subtract, keep or restore.
module iterative_restoring_divider_step #(
  parameter int W = 8
) (
  input  logic [W:0]   rem_in,
  input  logic         bit_in,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         q_bit
);
  logic [W+1:0] diff;

  assign diff    = {rem_in, bit_in} - {2'b00, divisor};
  assign q_bit   = ~diff[W+1];
  assign rem_out = q_bit ? diff[W:0] : {rem_in[W-1:0], bit_in};
endmodule

module iterative_restoring_divider #(
  parameter int DATA_WIDTH     = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  iterative_restoring_divider_if.slave bus
);
  localparam int W   = DATA_WIDTH;
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = W / BPC;
  localparam int CW  = $clog2(N + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  dvs_q;
  logic [W:0]    rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          dbz;

  logic [BPC:0][W:0] rem_chain;
  logic [BPC-1:0]    qbits;
  logic [W-1:0]      quo_nxt;
  logic [W-1:0]      dvd_nxt;
  logic [W-1:0]      q_final;
  logic [W-1:0]      r_final;
  logic [W-1:0]      dvd_mag;
  logic [W-1:0]      dvs_mag;

  assign rem_chain[0] = rem_q;

  // Chained steps consume dividend bits MSB-first; first step yields the oldest quotient bit.
  for (genvar k = 0; k < BPC; k++) begin : g_step
    iterative_restoring_divider_step #(.W(W)) u_step (
      .rem_in  (rem_chain[k]),
      .bit_in  (dvd_q[W-1-k]),
      .divisor (dvs_q),
      .rem_out (rem_chain[k+1]),
      .q_bit   (qbits[BPC-1-k])
    );
  end

  assign quo_nxt = (quo_q << BPC) | W'(qbits);
  assign dvd_nxt = dvd_q << BPC;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
  logic sgn_in;

  assign sgn_in  = bus.signed_i;
  assign dvd_mag = (sgn_in && bus.dividend_i[W-1]) ? -bus.dividend_i : bus.dividend_i;
  assign dvs_mag = (sgn_in && bus.divisor_i[W-1])  ? -bus.divisor_i  : bus.divisor_i;
  // Magnitude quotient of -2^(W-1)/-1 is 2^(W-1), which already reads back as -2^(W-1).
  assign q_final = neg_q ? -quo_nxt : quo_nxt;
  assign r_final = neg_r ? -rem_chain[BPC][W-1:0] : rem_chain[BPC][W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && bus.data_valid_i) begin
      neg_q <= sgn_in & (bus.dividend_i[W-1] ^ bus.divisor_i[W-1]);
      neg_r <= sgn_in & bus.dividend_i[W-1];
    end
  end
`else
  assign dvd_mag = bus.dividend_i;
  assign dvs_mag = bus.divisor_i;
  assign q_final = quo_nxt;
  assign r_final = rem_chain[BPC][W-1:0];
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.data_valid_i) begin
            dvd_q <= dvd_mag;
            dvs_q <= dvs_mag;
            rem_q <= '0;
            quo_q <= '0;
            cnt   <= '0;
            if (bus.divisor_i == '0) begin
              // Raw dividend, not the magnitude, is returned on divide by zero.
              quotient  <= '1;
              remainder <= bus.dividend_i;
              dbz       <= 1'b1;
              state     <= DONE;
            end else begin
              state <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem_q <= rem_chain[BPC];
          quo_q <= quo_nxt;
          dvd_q <= dvd_nxt;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            quotient  <= q_final;
            remainder <= r_final;
            dbz       <= 1'b0;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o          = (state == IDLE);
  assign bus.data_valid_o     = (state == DONE);
  assign bus.quotient_o       = quotient;
  assign bus.remainder_o      = remainder;
  assign bus.divide_by_zero_o = dbz;
endmodule
